// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding word
// reads over req/gnt/rvalid, queues returned words in a small prefetch FIFO
// and presents the FIFO head to decode through registered pc/inst outputs.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_req_pc;
    logic             r_outstanding;
    logic             r_discard;
    logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]      r_fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_id_inst;
    logic             r_id_valid;

    logic             w_fifo_nempty;
    logic             w_pop;
    logic             w_push;
    logic             w_rsp;
    logic             w_req;
    logic             w_grant;
    logic [CNT_W:0]   w_occ;

    // Handshake decode: credit-based request gating and FIFO push/pop strobes.
    // Occupancy counts the outstanding read so a FIFO slot is reserved at issue.
    always_comb begin
        w_fifo_nempty = (r_count != {CNT_W{1'b0}});
        w_pop         = !stall_i && w_fifo_nempty && !flush_i;
        w_rsp         = imem_rvalid_i && r_outstanding;
        w_push        = w_rsp && !r_discard && !flush_i;
        w_occ         = {1'b0, r_count}
                      + (CNT_W+1)'(r_outstanding)
                      - (CNT_W+1)'(w_pop);
        w_req         = !rst && !flush_i
                      && (w_occ < (CNT_W+1)'(FIFO_DEPTH))
                      && (!r_outstanding || (imem_rvalid_i && !r_discard));
        w_grant       = w_req && imem_gnt_i;
    end

    // Fetch PC, outstanding-read tracking and post-flush discard of a stale response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= 32'h0000_0000;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else if (flush_i) begin
            r_fetch_pc <= {flush_pc_i[31:2], 2'b00};
            if (r_outstanding && !imem_rvalid_i) begin
                // Response still in flight: remember to drop it when it lands.
                r_discard <= 1'b1;
            end else begin
                r_outstanding <= 1'b0;
                r_discard     <= 1'b0;
            end
        end else begin
            if (w_grant) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else if (w_rsp) begin
                r_outstanding <= 1'b0;
            end
            if (w_rsp && r_discard) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Prefetch FIFO pointers and count; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Prefetch FIFO storage: write the returned word tagged with its request PC.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_req_pc;
            r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
        end
    end

    // Decode-facing registers: clear on flush, hold on stall, else take the FIFO head.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
        end else if (stall_i) begin
            r_id_valid <= r_id_valid;
            r_id_pc    <= r_id_pc;
            r_id_inst  <= r_id_inst;
        end else if (w_fifo_nempty) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_fifo_pc[r_rd_ptr];
            r_id_inst  <= r_fifo_inst[r_rd_ptr];
        end else begin
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= 32'h0000_0000;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign id_pc_o     = r_id_pc;
    assign id_inst_o   = r_id_inst;
    assign id_valid_o  = r_id_valid;

endmodule
